// File: rtl/gp_cmd_processor.sv
// Graphics command processor: walks a command list in memory and rasterises FILL/RECT
// commands into the frame buffer as 32-bit pixel writes, one pixel per accepted write.
module gp_cmd_processor #(
   parameter int FB_WIDTH  = 1024,
   parameter int FB_HEIGHT = 768,
   parameter int FB_STRIDE = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] gp_code,
   input  logic [31:0] gp_frame,
   input  logic        gp_valid,
   output logic        busy,
   output logic        done,
   output logic        rd_req,
   output logic [31:0] rd_addr,
   input  logic        rd_ready,
   input  logic        rd_valid,
   input  logic [31:0] rd_data,
   output logic        wr_req,
   output logic [31:0] wr_addr,
   output logic [31:0] wr_data,
   input  logic        wr_ready
);

   localparam logic [15:0] X_MAX     = 16'(FB_WIDTH - 1);
   localparam logic [15:0] Y_MAX     = 16'(FB_HEIGHT - 1);
   localparam logic [31:0] ROW_BYTES = 32'(FB_STRIDE) << 2;

   localparam logic [7:0] OP_STOP = 8'h00;
   localparam logic [7:0] OP_FILL = 8'h01;
   localparam logic [7:0] OP_RECT = 8'h02;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH0,
      S_WAIT0,
      S_FETCH1,
      S_WAIT1,
      S_FETCH2,
      S_WAIT2,
      S_DRAW,
      S_STOP
   } state_t;

   state_t      r_state;
   logic [31:0] r_cmd_ptr;
   logic [31:0] r_frame_base;
   logic [23:0] r_color;
   logic [15:0] r_x0;
   logic [15:0] r_y0;
   logic [15:0] r_x1;
   logic [15:0] r_y1;
   logic [15:0] r_x;
   logic [15:0] r_y;
   logic [31:0] r_row_addr;
   logic        r_busy;
   logic        r_done;
   logic        r_rd_req;
   logic [31:0] r_rd_addr;
   logic        r_wr_req;
   logic [31:0] r_wr_addr;
   logic [31:0] r_wr_data;

   logic [7:0]  w_opcode;
   logic [15:0] w_x1_clip;
   logic [15:0] w_y1_clip;
   logic        w_empty;
   logic [31:0] w_rect_base;

   // word2 is clipped on arrival; corner 0 was latched from word1 a few cycles earlier
   assign w_opcode    = rd_data[31:24];
   assign w_x1_clip   = (rd_data[15:0]  > X_MAX) ? X_MAX : rd_data[15:0];
   assign w_y1_clip   = (rd_data[31:16] > Y_MAX) ? Y_MAX : rd_data[31:16];
   assign w_empty     = (r_x0 > w_x1_clip) || (r_y0 > w_y1_clip);
   assign w_rect_base = r_frame_base + ({16'h0000, r_y0} * ROW_BYTES) + {14'h0000, r_x0, 2'b00};

   assign busy    = r_busy;
   assign done    = r_done;
   assign rd_req  = r_rd_req;
   assign rd_addr = r_rd_addr;
   assign wr_req  = r_wr_req;
   assign wr_addr = r_wr_addr;
   assign wr_data = r_wr_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_cmd_ptr    <= 32'h0;
         r_frame_base <= 32'h0;
         r_color      <= 24'h0;
         r_x0         <= 16'h0;
         r_y0         <= 16'h0;
         r_x1         <= 16'h0;
         r_y1         <= 16'h0;
         r_x          <= 16'h0;
         r_y          <= 16'h0;
         r_row_addr   <= 32'h0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_rd_req     <= 1'b0;
         r_rd_addr    <= 32'h0;
         r_wr_req     <= 1'b0;
         r_wr_addr    <= 32'h0;
         r_wr_data    <= 32'h0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (gp_valid) begin
                  r_cmd_ptr    <= gp_code;
                  r_frame_base <= gp_frame;
                  r_busy       <= 1'b1;
                  r_rd_req     <= 1'b1;
                  r_rd_addr    <= gp_code;
                  r_state      <= S_FETCH0;
               end
            end

            S_FETCH0, S_FETCH1, S_FETCH2: begin
               if (rd_ready) begin
                  r_rd_req  <= 1'b0;
                  r_cmd_ptr <= r_cmd_ptr + 32'd4;
                  r_state   <= (r_state == S_FETCH0) ? S_WAIT0 :
                               (r_state == S_FETCH1) ? S_WAIT1 : S_WAIT2;
               end
            end

            S_WAIT0: begin
               if (rd_valid) begin
                  r_color <= rd_data[23:0];
                  case (w_opcode)
                     OP_STOP: begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_STOP;
                     end
                     OP_FILL: begin
                        r_x0       <= 16'h0;
                        r_y0       <= 16'h0;
                        r_x1       <= X_MAX;
                        r_y1       <= Y_MAX;
                        r_x        <= 16'h0;
                        r_y        <= 16'h0;
                        r_row_addr <= r_frame_base;
                        r_wr_addr  <= r_frame_base;
                        r_wr_data  <= {8'h00, rd_data[23:0]};
                        r_wr_req   <= 1'b1;
                        r_state    <= S_DRAW;
                     end
                     OP_RECT: begin
                        r_rd_req  <= 1'b1;
                        r_rd_addr <= r_cmd_ptr;
                        r_state   <= S_FETCH1;
                     end
                     default: begin
                        r_rd_req  <= 1'b1;
                        r_rd_addr <= r_cmd_ptr;
                        r_state   <= S_FETCH0;
                     end
                  endcase
               end
            end

            S_WAIT1: begin
               if (rd_valid) begin
                  r_x0      <= rd_data[15:0];
                  r_y0      <= rd_data[31:16];
                  r_rd_req  <= 1'b1;
                  r_rd_addr <= r_cmd_ptr;
                  r_state   <= S_FETCH2;
               end
            end

            S_WAIT2: begin
               if (rd_valid) begin
                  r_x1 <= w_x1_clip;
                  r_y1 <= w_y1_clip;
                  if (w_empty) begin
                     r_rd_req  <= 1'b1;
                     r_rd_addr <= r_cmd_ptr;
                     r_state   <= S_FETCH0;
                  end else begin
                     r_x        <= r_x0;
                     r_y        <= r_y0;
                     r_row_addr <= w_rect_base;
                     r_wr_addr  <= w_rect_base;
                     r_wr_data  <= {8'h00, r_color};
                     r_wr_req   <= 1'b1;
                     r_state    <= S_DRAW;
                  end
               end
            end

            // Addresses advance incrementally: +4 along a row, +stride bytes per new row.
            S_DRAW: begin
               if (wr_ready) begin
                  if (r_x == r_x1) begin
                     if (r_y == r_y1) begin
                        r_wr_req  <= 1'b0;
                        r_rd_req  <= 1'b1;
                        r_rd_addr <= r_cmd_ptr;
                        r_state   <= S_FETCH0;
                     end else begin
                        r_x        <= r_x0;
                        r_y        <= r_y + 16'd1;
                        r_row_addr <= r_row_addr + ROW_BYTES;
                        r_wr_addr  <= r_row_addr + ROW_BYTES;
                     end
                  end else begin
                     r_x       <= r_x + 16'd1;
                     r_wr_addr <= r_wr_addr + 32'd4;
                  end
               end
            end

            S_STOP: begin
               r_state <= S_IDLE;
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gp_cmd_processor.sv
// Directed bench for gp_cmd_processor on an 8x4 frame: memory responder, bus monitor, hand-computed vectors.
module tb_gp_cmd_processor;

   localparam logic [31:0] CODE  = 32'h1000_0000;
   localparam logic [31:0] FRAME = 32'h1F00_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] gp_code = 32'h0;
   logic [31:0] gp_frame = 32'h0;
   logic        gp_valid = 1'b0;
   logic        busy;
   logic        done;
   logic        rd_req;
   logic [31:0] rd_addr;
   logic        rd_ready = 1'b1;
   logic        rd_valid = 1'b0;
   logic [31:0] rd_data = 32'h0;
   logic        wr_req;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic        wr_ready = 1'b1;

   always #5 clk = ~clk;

   gp_cmd_processor #(
      .FB_WIDTH  (8),
      .FB_HEIGHT (4),
      .FB_STRIDE (8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .gp_code  (gp_code),
      .gp_frame (gp_frame),
      .gp_valid (gp_valid),
      .busy     (busy),
      .done     (done),
      .rd_req   (rd_req),
      .rd_addr  (rd_addr),
      .rd_ready (rd_ready),
      .rd_valid (rd_valid),
      .rd_data  (rd_data),
      .wr_req   (wr_req),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_ready (wr_ready)
   );

   logic [31:0] mem [0:31];
   int n_chk  = 0;
   int n_pass = 0;

   // bus log written only by the monitor process
   int          cyc = 0;
   logic [31:0] rd_addr_q [$];
   int          rd_cyc_q  [$];
   logic [31:0] wr_addr_q [$];
   logic [31:0] wr_data_q [$];
   int          wr_cyc_q  [$];
   int done_cnt  = 0;
   int both_cnt  = 0;
   int doneb_cnt = 0;
   int stab_cnt  = 0;
   int ovl_cnt   = 0;

   // 0 = ready low, 1 = ready high, 2 = random ready and random read latency
   int rd_mode  = 1;
   int wr_mode  = 1;
   int kick_req = 0;

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      logic [31:0] off;
      off = a - CODE;
      if (off < 32'd128) return mem[off[6:2]];
      return 32'h0;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // Monitor samples pre-edge values at posedge; responder drives inputs at negedge.
   always begin
      logic        pend;
      int          pend_dly;
      logic [31:0] pend_addr;
      logic        prev_wr_hold;
      logic        prev_rd_hold;
      logic [31:0] prev_wa;
      logic [31:0] prev_wd;
      logic [31:0] prev_ra;
      int          kick_seen;
      pend = 1'b0; pend_dly = 0; pend_addr = 32'h0;
      prev_wr_hold = 1'b0; prev_rd_hold = 1'b0;
      prev_wa = 32'h0; prev_wd = 32'h0; prev_ra = 32'h0;
      kick_seen = 0;
      forever begin
         @(posedge clk);
         cyc++;
         if (rst) begin
            pend = 1'b0;
            prev_wr_hold = 1'b0;
            prev_rd_hold = 1'b0;
         end else begin
            if (rd_req && wr_req) both_cnt++;
            if (done && busy) doneb_cnt++;
            if (done) done_cnt++;
            if (prev_wr_hold && (!wr_req || wr_addr != prev_wa || wr_data != prev_wd)) stab_cnt++;
            if (prev_rd_hold && (!rd_req || rd_addr != prev_ra)) stab_cnt++;
            prev_wr_hold = wr_req && !wr_ready;
            prev_rd_hold = rd_req && !rd_ready;
            prev_wa = wr_addr;
            prev_wd = wr_data;
            prev_ra = rd_addr;
            if (wr_req && wr_ready) begin
               wr_addr_q.push_back(wr_addr);
               wr_data_q.push_back(wr_data);
               wr_cyc_q.push_back(cyc);
            end
            if (rd_req && rd_ready) begin
               if (pend) ovl_cnt++;
               rd_addr_q.push_back(rd_addr);
               rd_cyc_q.push_back(cyc);
               pend      = 1'b1;
               pend_addr = rd_addr;
               pend_dly  = (rd_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            end
         end
         @(negedge clk);
         rd_valid = 1'b0;
         if (pend) begin
            if (pend_dly == 0) begin
               rd_valid = 1'b1;
               rd_data  = mem_rd(pend_addr);
               pend     = 1'b0;
            end else begin
               pend_dly--;
            end
         end
         if (kick_req != kick_seen) begin
            kick_seen = kick_req;
            rd_valid  = 1'b1;
            rd_data   = 32'h0100_0055;
         end
         rd_ready = (rd_mode == 2) ? 1'($urandom_range(0, 1)) : (rd_mode == 1);
         wr_ready = (wr_mode == 2) ? 1'($urandom_range(0, 1)) : (wr_mode == 1);
      end
   end

   task automatic go(input logic [31:0] code, input string tag);
      @(negedge clk);
      gp_code  = code;
      gp_frame = FRAME;
      gp_valid = 1'b1;
      @(negedge clk);
      gp_valid = 1'b0;
      check_eq({tag, "_start_busy"}, 32'(busy), 32'd1);
      check_eq({tag, "_start_rdreq"}, 32'(rd_req), 32'd1);
      check_eq({tag, "_start_rdaddr"}, rd_addr, code);
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check_eq({tag, "_finished"}, 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
   endtask

   task automatic check_wr(input string tag, input int wb, input int n,
                           input logic [31:0] ea [8], input logic [31:0] ed);
      check_eq({tag, "_nwr"}, 32'(wr_addr_q.size() - wb), 32'(n));
      for (int i = 0; i < n; i++) begin
         if (wb + i < wr_addr_q.size()) begin
            check_eq($sformatf("%s_wa%0d", tag, i), wr_addr_q[wb + i], ea[i]);
            check_eq($sformatf("%s_wd%0d", tag, i), wr_data_q[wb + i], ed);
         end
      end
   endtask

   task automatic check_fill(input string tag, input int wb, input int rb, input int db);
      check_eq({tag, "_nwr"}, 32'(wr_addr_q.size() - wb), 32'd32);
      for (int i = 0; i < 32; i++) begin
         if (wb + i < wr_addr_q.size()) begin
            check_eq($sformatf("%s_wa%0d", tag, i), wr_addr_q[wb + i], FRAME + 32'(4 * i));
            check_eq($sformatf("%s_wd%0d", tag, i), wr_data_q[wb + i], 32'h00AB_CDEF);
         end
      end
      check_eq({tag, "_nrd"}, 32'(rd_addr_q.size() - rb), 32'd2);
      if (rd_addr_q.size() >= rb + 2) begin
         check_eq({tag, "_rd0"}, rd_addr_q[rb], CODE);
         check_eq({tag, "_rd1"}, rd_addr_q[rb + 1], CODE + 32'd4);
      end
      check_eq({tag, "_done"}, 32'(done_cnt - db), 32'd1);
   endtask

   initial begin
      int rb;
      int wb;
      int db;
      int n;
      logic [31:0] ea [8];

      for (int i = 0; i < 32; i++) mem[i] = 32'h0;

      // reset values
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_rdreq", 32'(rd_req), 32'd0);
      check_eq("rst_wrreq", 32'(wr_req), 32'd0);
      check_eq("rst_rdaddr", rd_addr, 32'h0);
      check_eq("rst_wraddr", wr_addr, 32'h0);
      check_eq("rst_wrdata", wr_data, 32'h0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // FILL, no stalls
      mem[0] = 32'h01AB_CDEF; mem[1] = 32'h0;
      rb = rd_addr_q.size(); wb = wr_addr_q.size(); db = done_cnt;
      go(CODE, "fill");
      wait_idle("fill");
      check_fill("fill", wb, rb, db);
      if (wr_cyc_q.size() >= wb + 32 && rd_cyc_q.size() >= rb + 2) begin
         check_eq("fill_first_lat", 32'(wr_cyc_q[wb] - rd_cyc_q[rb]), 32'd2);
         check_eq("fill_burst_len", 32'(wr_cyc_q[wb + 31] - wr_cyc_q[wb]), 32'd31);
         check_eq("fill_next_fetch", 32'(rd_cyc_q[rb + 1] - wr_cyc_q[wb + 31]), 32'd1);
      end

      // RECT (2,1)-(3,2)
      mem[0] = 32'h0200_0011; mem[1] = 32'h0001_0002; mem[2] = 32'h0002_0003; mem[3] = 32'h0;
      rb = rd_addr_q.size(); wb = wr_addr_q.size(); db = done_cnt;
      go(CODE, "rect");
      wait_idle("rect");
      ea = '{32'h1F00_0028, 32'h1F00_002C, 32'h1F00_0048, 32'h1F00_004C,
             32'h0, 32'h0, 32'h0, 32'h0};
      check_wr("rect", wb, 4, ea, 32'h0000_0011);
      check_eq("rect_nrd", 32'(rd_addr_q.size() - rb), 32'd4);
      check_eq("rect_done", 32'(done_cnt - db), 32'd1);

      // clipped RECT then an empty RECT
      mem[0] = 32'h0200_0022; mem[1] = 32'h0000_0006; mem[2] = 32'h0009_000F;
      mem[3] = 32'h0200_0033; mem[4] = 32'h0000_0005; mem[5] = 32'h0000_0003; mem[6] = 32'h0;
      rb = rd_addr_q.size(); wb = wr_addr_q.size(); db = done_cnt;
      go(CODE, "clip");
      wait_idle("clip");
      ea = '{32'h1F00_0018, 32'h1F00_001C, 32'h1F00_0038, 32'h1F00_003C,
             32'h1F00_0058, 32'h1F00_005C, 32'h1F00_0078, 32'h1F00_007C};
      check_wr("clip", wb, 8, ea, 32'h0000_0022);
      check_eq("clip_nrd", 32'(rd_addr_q.size() - rb), 32'd7);
      if (rd_addr_q.size() >= rb + 7) begin
         check_eq("clip_last_rd", rd_addr_q[rb + 6], CODE + 32'h18);
         check_eq("empty_next_fetch", 32'(rd_cyc_q[rb + 6] - rd_cyc_q[rb + 5]), 32'd2);
      end
      check_eq("clip_done", 32'(done_cnt - db), 32'd1);

      // FILL under random stalls on both ports
      mem[0] = 32'h01AB_CDEF; mem[1] = 32'h0;
      rd_mode = 2; wr_mode = 2;
      rb = rd_addr_q.size(); wb = wr_addr_q.size(); db = done_cnt;
      go(CODE, "stall");
      wait_idle("stall");
      check_fill("stall", wb, rb, db);
      rd_mode = 1; wr_mode = 1;

      // unknown opcode, gp_valid while busy and in the STOP cycle
      mem[0] = 32'h7F00_0000; mem[1] = 32'h0;
      mem[16] = 32'h0112_3456; mem[17] = 32'h0;
      rb = rd_addr_q.size(); wb = wr_addr_q.size(); db = done_cnt;
      go(CODE, "nop");
      gp_code = CODE + 32'h40; gp_valid = 1'b1;
      @(negedge clk);
      gp_valid = 1'b0;
      n = 0;
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_eq("nop_done_seen", 32'(done), 32'd1);
      check_eq("nop_busy_at_done", 32'(busy), 32'd0);
      gp_code = CODE + 32'h40; gp_valid = 1'b1;
      @(negedge clk);
      gp_valid = 1'b0;
      repeat (6) @(negedge clk);
      check_eq("nop_idle_busy", 32'(busy), 32'd0);
      check_eq("nop_nrd", 32'(rd_addr_q.size() - rb), 32'd2);
      if (rd_addr_q.size() >= rb + 2) begin
         check_eq("nop_rd0", rd_addr_q[rb], CODE);
         check_eq("nop_rd1", rd_addr_q[rb + 1], CODE + 32'd4);
      end
      check_eq("nop_nwr", 32'(wr_addr_q.size() - wb), 32'd0);
      check_eq("nop_done", 32'(done_cnt - db), 32'd1);

      // reset in the middle of a stalled DRAW
      mem[0] = 32'h01AB_CDEF; mem[1] = 32'h0;
      wr_mode = 0;
      go(CODE, "rstd");
      n = 0;
      while (!wr_req && n < 50) begin
         @(negedge clk);
         n++;
      end
      check_eq("rstd_draw_reached", 32'(wr_req), 32'd1);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_eq("rstd_wrreq", 32'(wr_req), 32'd0);
      check_eq("rstd_busy", 32'(busy), 32'd0);
      check_eq("rstd_rdreq", 32'(rd_req), 32'd0);
      check_eq("rstd_wraddr", wr_addr, 32'h0);
      rst = 1'b0;
      rb = rd_addr_q.size(); wb = wr_addr_q.size();
      wr_mode = 1;
      kick_req++;
      repeat (6) @(negedge clk);
      check_eq("rstd_after_rdreq", 32'(rd_req), 32'd0);
      check_eq("rstd_after_wrreq", 32'(wr_req), 32'd0);
      check_eq("rstd_after_busy", 32'(busy), 32'd0);
      check_eq("rstd_after_nrd", 32'(rd_addr_q.size() - rb), 32'd0);
      check_eq("rstd_after_nwr", 32'(wr_addr_q.size() - wb), 32'd0);

      // whole-run bus properties
      check_eq("ports_both_high", 32'(both_cnt), 32'd0);
      check_eq("done_with_busy", 32'(doneb_cnt), 32'd0);
      check_eq("req_stability", 32'(stab_cnt), 32'd0);
      check_eq("reads_outstanding", 32'(ovl_cnt), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed so far", n_pass, n_chk);
      $fatal(1);
   end

endmodule

// File: doc/gp_cmd_processor.md
Name: gp_cmd_processor

Overview:
- Graphics command processor directly downstream of the CPU's gp_code/gp_frame/gp_valid outputs.
- On a gp_valid pulse it fetches a command list from memory starting at gp_code. It executes FILL/RECT draw commands by writing 32-bit pixels into the frame buffer based at gp_frame.
- Memory access uses a single read port (command fetch) and a single write port (pixel stores); both feed the memory arbiter.
- Signals completion to the CPU via done/busy.

Parameters:
- FB_WIDTH, 1024, visible pixels per row.
- FB_HEIGHT, 768, visible rows.
- FB_STRIDE, 1024, pixels per row in memory; must be >= FB_WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- gp_code  in  32  byte address of first command word
- gp_frame  in  32  byte address of pixel (0,0)
- gp_valid  in  1  start pulse
- busy  out  1  high from accepted start until STOP handled
- done  out  1  one-cycle pulse when STOP executes
- rd_req  out  1  command read request
- rd_addr  out  32  command word byte address
- rd_ready  in  1  read request accepted this cycle
- rd_valid  in  1  read data valid
- rd_data  in  32  command word
- wr_req  out  1  pixel write request
- wr_addr  out  32  pixel byte address
- wr_data  out  32  pixel value
- wr_ready  in  1  write accepted this cycle

Behaviour:
- Reset: clk is the clock; rst is synchronous, active-high. Reset forces state IDLE; busy, done, rd_req and wr_req are 0; rd_addr, wr_addr and wr_data are 0. Reset mid-operation abandons the list immediately, with no further requests. A pending rd_valid after reset is ignored.
- Handshake, both ports: req is held with stable addr/data until sampled with ready=1 at a rising edge. The transfer completes on that edge. At most one read is outstanding. Exactly one rd_valid (>=1 cycle after acceptance) is returned per accepted read.
- States: IDLE, FETCH0, WAIT0, FETCH1, WAIT1, FETCH2, WAIT2, DRAW, STOP.
- IDLE: gp_valid=1 latches cmd_ptr=gp_code and frame_base=gp_frame. busy=1 next cycle, with rd_req=1 and rd_addr=gp_code. gp_valid is ignored when not in IDLE.
- FETCHn: assert rd_req at cmd_ptr. On acceptance, cmd_ptr += 4 (32-bit wrap) and go to WAITn.
- WAIT0: on rd_valid, latch word0 and decode opcode word0[31:24]:
  - 0x00 STOP: go to STOP.
  - 0x01 FILL: x0=0, y0=0, x1=FB_WIDTH-1, y1=FB_HEIGHT-1; go to DRAW.
  - 0x02 RECT: go to FETCH1.
  - Any other value: NOP, go to FETCH0.
- RECT operands: word1={y0[31:16], x0[15:0]}, word2={y1[31:16], x1[15:0]}; inclusive corners, unsigned. WAIT1 latches word1 and goes to FETCH2; WAIT2 latches word2, clips, and goes to DRAW.
- Clipping: x1=min(x1,FB_WIDTH-1), y1=min(y1,FB_HEIGHT-1). If x0>x1 or y0>y1 after clipping, issue no writes and go to FETCH0.
- Colour: color = word0[23:0]; wr_data = {8'h00, color}.
- DRAW: raster order, x inner loop from (x0,y0) to (x1,y1).
  - Address: wr_addr = frame_base + ((y*FB_STRIDE + x) << 2), computed modulo 2^32.
  - Cycle-level: wr_req stays high through the rectangle. With wr_ready tied high there is one pixel per cycle.
  - Advance only on acceptance. After the last pixel (x1,y1) is accepted, wr_req drops next cycle and the state goes to FETCH0.
- STOP: done=1 for exactly one cycle and busy=0 in that same cycle; return to IDLE. A gp_valid in the STOP cycle is ignored.
- Ports are never active together: rd_req and wr_req are never both high.

Test Plan:
- Reset mid-DRAW with wr_ready held 0: assert rst for 1 cycle -> next cycle wr_req=0, busy=0, state IDLE. A subsequent rd_valid pulse causes no activity.
- Bench params FB_WIDTH=8, FB_HEIGHT=4, FB_STRIDE=8; gp_code=0x10000000, gp_frame=0x1F000000; list {0x01ABCDEF, 0x00000000}; ready tied 1, rd_valid 1 cycle after accept -> 32 writes at 0x1F000000..0x1F00007C step 4, all data 0x00ABCDEF; then a read at 0x10000004; then done pulses once.
- Same params, list {0x02000011, 0x00010002, 0x00020003, 0x00000000} -> 4 writes to (2,1),(3,1),(2,2),(3,2) at addresses 0x1F000028, 0x1F00002C, 0x1F000048, 0x1F00004C; data 0x00000011.
- RECT word1=0x00000006, word2=0x0009000F -> clipped to x 6..7, y 0..3: 8 writes. RECT word1=0x00000005, word2=0x00000003 -> zero writes, next fetch follows immediately.
- Random wr_ready/rd_ready stalls (50%) on the FILL list -> addr/data stable while req=1 and ready=0; the same 32 write addresses are seen in order with no duplicates; rd_req and wr_req are never both high.
- List {0x7F000000, 0x00000000} -> unknown opcode skipped; exactly 2 reads, 0 writes, done=1 for 1 cycle. A gp_valid pulse while busy=1 has no effect.
